ram_arbiter: RTL and testbench

Two-port arbiter that shares a single `model_ram` port between the ZAP instruction-fetch requester (port 0) and data requester (port 1). It turns per-requester strobe/ack handshakes into RAM read/write cycles, honours the RAM's one-cycle registered read latency and its `o_stall` back-pressure, and returns read data and acknowledge to the granted requester. It sits between the core's memory interfaces and the RAM model in the testbench top.

---
 rtl/ram_arbiter_pkg.sv | 30 +++
 rtl/ram_arbiter_rr_arb2.sv | 34 +++
 rtl/ram_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared types and constants for the two-port RAM arbiter:
//   - state_e   : arbiter FSM states (IDLE / ACCESS / RESP)
//   - P_IFETCH  : port index of the instruction-fetch requester
//   - P_DATA    : port index of the data requester
//   - req_t     : one latched RAM request (we, ben, addr, wdata)
//   - port_mask : one-hot mask for a port index
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic P_IFETCH = 1'b0;
    localparam logic P_DATA   = 1'b1;

    typedef struct packed {
        logic        we;
        logic [3:0]  ben;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [1:0] port_mask(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2
// Combinational two-way grant.
//   req_i   [1:0] : request per port
//   last_i        : index of the port served most recently
//   rr_en_i       : 1 = round-robin on contention, 0 = port 1 always wins
//   mask_i  [1:0] : ports excluded from this decision (the port being acked)
//   valid_o       : at least one unmasked request
//   gnt_o         : winning port index (only meaningful while valid_o)
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       rr_en_i,
    input  logic [1:0] mask_i,
    output logic       valid_o,
    output logic       gnt_o
);

    logic [1:0] req_m;

    always_comb begin
        req_m   = req_i & ~mask_i;
        valid_o = |req_m;
        gnt_o   = P_IFETCH;
        if (&req_m) begin
            // Contention: round-robin hands the grant to the port not served last.
            gnt_o = rr_en_i ? ~last_i : P_DATA;
        end else if (req_m[1]) begin
            gnt_o = P_DATA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-cycle-latency RAM port between the instruction-fetch
// requester (port 0) and the data requester (port 1).
//   RR_EN                      : 1 = round-robin, 0 = fixed priority to port 1
//   i_clk, i_reset_n           : clock, asynchronous active-low reset
//   i_pN_stb/we/ben/addr/wdata : request from port N, stb held until ack
//   o_pN_ack                   : one-cycle completion pulse for port N
//   o_pN_rdata                 : read data while o_pN_ack is high, else 0
//   o_ram_ren/wen/ben/addr/wdata : RAM command, enables high only in ACCESS
//   i_ram_rdata                : RAM registered read data
//   i_ram_stall                : RAM back-pressure, holds ACCESS while high
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_p0_stb,
    input  logic        i_p0_we,
    input  logic [3:0]  i_p0_ben,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    input  logic        i_p1_stb,
    input  logic        i_p1_we,
    input  logic [3:0]  i_p1_ben,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    output logic        o_p0_ack,
    output logic [31:0] o_p0_rdata,
    output logic        o_p1_ack,
    output logic [31:0] o_p1_rdata,
    output logic        o_ram_ren,
    output logic        o_ram_wen,
    output logic [3:0]  o_ram_ben,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_wdata,
    input  logic [31:0] i_ram_rdata,
    input  logic        i_ram_stall
);

    state_e     state_q;
    logic       gnt_q;
    logic       last_q;
    req_t       req_q;

    logic [1:0] arb_req;
    logic [1:0] arb_mask;
    logic       arb_valid;
    logic       arb_gnt;
    logic       resp_hold;
    req_t       req_sel;

    assign arb_req = {i_p1_stb, i_p0_stb};

    // While acking, the acked port's strobe is still high, so it is masked out.
    assign arb_mask = (state_q == RESP) ? port_mask(gnt_q) : 2'b00;

    // In fixed-priority mode port 1 must keep winning while it keeps its strobe
    // up. Its acked strobe cannot be told apart from a new request during RESP,
    // so after a port-1 ack the decision is deferred to IDLE, where its strobe
    // counts again.
    assign resp_hold = !RR_EN && (gnt_q == P_DATA);

    rr_arb2 u_arb (
        .req_i   (arb_req),
        .last_i  (last_q),
        .rr_en_i (RR_EN),
        .mask_i  (arb_mask),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt)
    );

    always_comb begin
        if (arb_gnt == P_DATA) begin
            req_sel = '{we: i_p1_we, ben: i_p1_ben, addr: i_p1_addr, wdata: i_p1_wdata};
        end else begin
            req_sel = '{we: i_p0_we, ben: i_p0_ben, addr: i_p0_addr, wdata: i_p0_wdata};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            gnt_q   <= P_IFETCH;
            last_q  <= P_DATA;
            req_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        req_q   <= req_sel;
                        gnt_q   <= arb_gnt;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A stalled edge leaves the command on the bus untouched.
                    if (!i_ram_stall) begin
                        last_q  <= gnt_q;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (arb_valid && !resp_hold) begin
                        req_q   <= req_sel;
                        gnt_q   <= arb_gnt;
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; reset clears them at once.
    assign o_ram_ren   = (state_q == ACCESS) && !req_q.we;
    assign o_ram_wen   = (state_q == ACCESS) &&  req_q.we;
    assign o_ram_ben   = req_q.ben;
    assign o_ram_addr  = req_q.addr;
    assign o_ram_wdata = req_q.wdata;

    assign o_p0_ack   = (state_q == RESP) && (gnt_q == P_IFETCH);
    assign o_p1_ack   = (state_q == RESP) && (gnt_q == P_DATA);
    assign o_p0_rdata = (o_p0_ack && !req_q.we) ? i_ram_rdata : 32'h0;
    assign o_p1_rdata = (o_p1_ack && !req_q.we) ? i_ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed scenarios plus a randomized two-requester phase checked against a
// shadow memory, fairness and handshake rules. A second instance with fixed
// priority is exercised by the priority scenario.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  stb;
    logic [1:0]  we;
    logic [3:0]  ben   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        ren, wen;
    logic [3:0]  ram_ben;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_stall;
    logic        ram_init;
    logic [31:0] mem    [64];
    logic [31:0] shadow [64];

    logic [1:0]  fp_stb;
    logic        fp_ack0, fp_ack1, fp_ren, fp_wen;
    logic [31:0] fp_rdata0, fp_rdata1, fp_ram_addr, fp_ram_wdata;
    logic [3:0]  fp_ram_ben;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ram_arbiter #(.RR_EN(1'b1)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_p0_stb(stb[0]), .i_p0_we(we[0]), .i_p0_ben(ben[0]), .i_p0_addr(addr[0]), .i_p0_wdata(wdata[0]),
        .i_p1_stb(stb[1]), .i_p1_we(we[1]), .i_p1_ben(ben[1]), .i_p1_addr(addr[1]), .i_p1_wdata(wdata[1]),
        .o_p0_ack(ack0), .o_p0_rdata(rdata0), .o_p1_ack(ack1), .o_p1_rdata(rdata1),
        .o_ram_ren(ren), .o_ram_wen(wen), .o_ram_ben(ram_ben), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .i_ram_stall(ram_stall)
    );

    ram_arbiter #(.RR_EN(1'b0)) dut_fp (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_p0_stb(fp_stb[0]), .i_p0_we(1'b0), .i_p0_ben(4'hF), .i_p0_addr(32'h80), .i_p0_wdata(32'h0),
        .i_p1_stb(fp_stb[1]), .i_p1_we(1'b0), .i_p1_ben(4'hF), .i_p1_addr(32'h40), .i_p1_wdata(32'h0),
        .o_p0_ack(fp_ack0), .o_p0_rdata(fp_rdata0), .o_p1_ack(fp_ack1), .o_p1_rdata(fp_rdata1),
        .o_ram_ren(fp_ren), .o_ram_wen(fp_wen), .o_ram_ben(fp_ram_ben), .o_ram_addr(fp_ram_addr),
        .o_ram_wdata(fp_ram_wdata), .i_ram_rdata(32'hC0FFEE00), .i_ram_stall(1'b0)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h11223344;
        return 32'h5A00_0000 ^ (i * 32'h0001_0203);
    endfunction

    // RAM model: one-cycle registered read, nothing happens on a stalled edge.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (!ram_stall) begin
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (ram_ben[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
            if (ren) ram_rdata <= mem[ram_addr[7:2]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request on port p (called just after a rising edge) and wait
    // for its ack. stall_n stalled edges are inserted once ACCESS is seen.
    task automatic single_access(input int p, input logic w, input logic [3:0] be,
                                 input logic [31:0] a, input logic [31:0] wd, input int stall_n,
                                 output int lat, output logic [31:0] rd, output int en_cycles);
        int          stall_left;
        logic        got;
        logic [31:0] first_addr;
        logic [3:0]  first_ben;
        logic        first_en;
        stall_left = stall_n;
        got = 1'b0; lat = 0; rd = 32'h0; en_cycles = 0;
        first_addr = 32'h0; first_ben = 4'h0; first_en = 1'b0;
        stb[p] = 1'b1; we[p] = w; ben[p] = be; addr[p] = a; wdata[p] = wd;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (ren | wen) begin
                if (en_cycles == 0) begin
                    first_addr = ram_addr; first_ben = ram_ben; first_en = wen;
                end else begin
                    check_eq("hold_addr", ram_addr, first_addr);
                    check_eq("hold_ben", {28'h0, ram_ben}, {28'h0, first_ben});
                    check_eq("hold_wen", {31'h0, wen}, {31'h0, first_en});
                end
                en_cycles++;
            end
            if ((ren | wen) && stall_left > 0) begin
                ram_stall = 1'b1;
                stall_left--;
            end else begin
                ram_stall = 1'b0;
            end
            if ((p == 0) ? ack0 : ack1) begin
                got = 1'b1;
                lat = c;
                rd  = (p == 0) ? rdata0 : rdata1;
            end
        end
        if (!got) check_eq("ack_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        stb[p] = 1'b0;
        $display("txn port=%0d we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h lat=%0d",
                 p, w, a, wd, rd, lat);
    endtask

    task automatic rand_req(input int p);
        we[p]    = 1'($urandom % 2);
        ben[p]   = 4'($urandom % 16);
        addr[p]  = 32'($urandom_range(0, 63));
        wdata[p] = $urandom;
    endtask

    localparam int N_RAND = 200;

    initial begin
        int          lat, en_c, cyc, nack, last_cyc, issued, last_port;
        int          wait_c [2];
        int          fp0, fp1;
        logic [31:0] rd;
        logic        found, other_wait, done0, done1;
        logic [1:0]  prev_ack, cur_ack;
        logic [31:0] cur_rd [2];
        int          widx;

        rst_n = 1'b0; stb = 2'b00; we = 2'b00; fp_stb = 2'b00;
        for (int p = 0; p < 2; p++) begin
            ben[p] = 4'h0; addr[p] = 32'h0; wdata[p] = 32'h0;
        end
        ram_stall = 1'b0; ram_init = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        @(negedge clk);
        check_eq("rst_ack0", {31'h0, ack0}, 32'h0);
        check_eq("rst_ack1", {31'h0, ack1}, 32'h0);
        check_eq("rst_rdata0", rdata0, 32'h0);
        check_eq("rst_rdata1", rdata1, 32'h0);
        check_eq("rst_ren", {31'h0, ren}, 32'h0);
        check_eq("rst_wen", {31'h0, wen}, 32'h0);
        check_eq("rst_ben", {28'h0, ram_ben}, 32'h0);
        check_eq("rst_addr", ram_addr, 32'h0);
        check_eq("rst_wdata", ram_wdata, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single read
        @(posedge clk); #1;
        single_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 0, lat, rd, en_c);
        check_eq("rd_lat", lat, 3);
        check_eq("rd_ren_cycles", en_c, 1);
        check_eq("rd_data", rd, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("ack_pulse", {31'h0, ack0}, 32'h0);
        @(posedge clk); #1;

        // Byte write then read-back
        single_access(1, 1'b1, 4'b0010, 32'h20, 32'h0000AB00, 0, lat, rd, en_c);
        check_eq("wr_lat", lat, 3);
        check_eq("wr_rdata", rd, 32'h0);
        single_access(1, 1'b0, 4'hF, 32'h20, 32'h0, 0, lat, rd, en_c);
        check_eq("wr_readback", rd, 32'h1122AB44);

        // Stall for three edges
        single_access(0, 1'b0, 4'hF, 32'h10, 32'h0, 3, lat, rd, en_c);
        check_eq("stall_lat", lat, 6);
        check_eq("stall_en_cycles", en_c, 4);
        check_eq("stall_data", rd, 32'hDEADBEEF);

        // Round-robin contention with both strobes up from reset
        rst_n = 1'b0;
        stb = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h20;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nack = 0; last_cyc = 0;
        for (cyc = 1; cyc <= 40 && nack < 6; cyc++) begin
            @(negedge clk);
            if (ack0 | ack1) begin
                check_eq("rr_port", {31'h0, ack1}, 32'(nack % 2));
                check_eq("rr_rdata", ack1 ? rdata1 : rdata0, ack1 ? 32'h1122AB44 : 32'hDEADBEEF);
                if (nack > 0) check_eq("rr_gap", cyc - last_cyc, 2);
                $display("txn rr ack port=%0d cycle=%0d", ack1, cyc);
                last_cyc = cyc;
                nack++;
            end
        end
        check_eq("rr_count", nack, 6);
        @(posedge clk); #1 stb = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Fixed priority: port 1 holds the RAM while it keeps requesting
        fp_stb = 2'b11; fp0 = 0; fp1 = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fp_ack0) fp0++;
            if (fp_ack1) begin
                fp1++;
                check_eq("fp_rdata", fp_rdata1, 32'hC0FFEE00);
            end
            if (fp_ren | fp_wen) check_eq("fp_addr", fp_ram_addr, 32'h40);
        end
        check_eq("fp_p0_starved", fp0, 0);
        check_eq("fp_p1_served", {31'h0, fp1 >= 3}, 32'h1);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = fp_ack1;
        end
        @(posedge clk); #1 fp_stb = 2'b01;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (fp_ack1) check_eq("fp_p1_after_drop", 32'h1, 32'h0);
            found = fp_ack0;
        end
        check_eq("fp_p0_after_drop", {31'h0, found}, 32'h1);
        $display("txn fp p1_acks=%0d p0_served=%0d", fp1, found);
        @(posedge clk); #1 fp_stb = 2'b00;

        // Reset in the middle of ACCESS
        @(posedge clk); #1;
        stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h14;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = ren;
        end
        check_eq("mid_access_seen", {31'h0, found}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_ren", {31'h0, ren}, 32'h0);
        check_eq("mid_wen", {31'h0, wen}, 32'h0);
        check_eq("mid_ack", {31'h0, ack0}, 32'h0);
        check_eq("mid_addr", ram_addr, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("mid_noack", {31'h0, ack0}, 32'h0);
        end
        @(posedge clk); #1;
        stb[0] = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        single_access(0, 1'b0, 4'hF, 32'h14, 32'h0, 0, lat, rd, en_c);
        check_eq("post_rst_lat", lat, 3);
        check_eq("post_rst_data", rd, init_word(5));

        // Randomized traffic against a shadow memory
        ram_init = 1'b1;
        @(posedge clk); #1 ram_init = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        issued = 0; prev_ack = 2'b00; other_wait = 1'b0; last_port = 0;
        wait_c[0] = 0; wait_c[1] = 0; done0 = 1'b0; done1 = 1'b0;
        for (cyc = 0; cyc < 20000 && (issued < N_RAND || stb != 2'b00); cyc++) begin
            @(negedge clk);
            cur_ack = {ack1, ack0};
            cur_rd[0] = rdata0; cur_rd[1] = rdata1;
            if (ren | wen) check_eq("en_excl", {31'h0, ren & wen}, 32'h0);
            if (|cur_ack) check_eq("ack_excl", {31'h0, &cur_ack}, 32'h0);
            for (int p = 0; p < 2; p++) begin
                if (cur_ack[p]) begin
                    check_eq("ack_gap", {31'h0, prev_ack[p]}, 32'h0);
                    if (other_wait) check_eq("rr_order", p, 1 - last_port);
                    widx = int'(addr[p][7:2]);
                    if (we[p]) begin
                        for (int b = 0; b < 4; b++)
                            if (ben[p][b]) shadow[widx][b*8 +: 8] = wdata[p][b*8 +: 8];
                        check_eq("rand_wr_rdata", cur_rd[p], 32'h0);
                    end else begin
                        check_eq("rand_rd_data", cur_rd[p], shadow[widx]);
                    end
                    $display("txn rand port=%0d we=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h",
                             p, we[p], addr[p], wdata[p], cur_rd[p]);
                    last_port  = p;
                    other_wait = stb[1 - p];
                    if (p == 0) done0 = 1'b1; else done1 = 1'b1;
                    wait_c[p] = 0;
                end else if (stb[p]) begin
                    wait_c[p]++;
                end
            end
            prev_ack = cur_ack;
            ram_stall = ($urandom % 4) == 0;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? done0 : done1) begin
                    if (p == 0) done0 = 1'b0; else done1 = 1'b0;
                    stb[p] = 1'b0;
                    if (issued < N_RAND && ($urandom % 2) == 1) begin
                        rand_req(p); stb[p] = 1'b1; issued++;
                    end
                end else if (stb[p] && wait_c[p] > 60) begin
                    check_eq("rand_timeout", wait_c[p], 0);
                    stb[p] = 1'b0; wait_c[p] = 0;
                end else if (!stb[p] && issued < N_RAND && ($urandom % 3) == 0) begin
                    rand_req(p); stb[p] = 1'b1; issued++;
                end
            end
        end
        check_eq("rand_drained", {30'h0, stb}, 32'h0);
        ram_stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
